// File: rtl/matrix_vector_engine_pkg.sv
// Shared definitions for the matrix-vector engine.
//   state_t     : controller state encoding
//   byte_offset : element index -> byte offset (index * bytes per element)
package matrix_vector_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAT,
        LOAD_VEC,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    function automatic logic [63:0] byte_offset(input logic [31:0] index,
                                                input int unsigned bytes_per_elem);
        return 64'(index) * 64'(bytes_per_elem);
    endfunction

endpackage

// File: rtl/matrix_vector_engine_mac.sv
// mac_unit: registered unsigned multiply-accumulate, modulo 2^WIDTH.
//   clk, rst  : clock, asynchronous active-high reset (clears acc)
//   clear     : with en, load acc with a*b (first term of a row)
//   en        : accumulate this cycle
//   a, b      : operands
//   acc       : accumulated value
module mac_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);

    function automatic logic [WIDTH-1:0] wrap_mul(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        return x * y;
    endfunction

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        return x + y;
    endfunction

    logic [WIDTH-1:0] prod_p0;

    assign prod_p0 = wrap_mul(a, b);

    // stage p0 -> p1: product folded into the accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= clear ? prod_p0 : wrap_add(acc, prod_p0);
    end

endmodule

// File: rtl/matrix_vector_engine.sv
// matrix_vector_engine: fetches an N x N matrix (row-major) and a stream of
// N-element vectors over a single-outstanding read port, computes M*v (or
// M^T*v) one MAC per cycle, and writes each result element over a write port.
//   start/transpose/reuseMatrix/workItemCount/matrixAddr/dataInAddr/dataOutAddr
//                  : job request and parameters, captured when start is seen in IDLE
//   rd_req/rd_addr/rd_gnt, rd_valid/rd_data : read request and returned data
//   wr_req/wr_addr/wr_data/wr_gnt           : write request
//   busy  : high outside IDLE;  done : one-cycle pulse in DONE
// Timing when rd_gnt is high in the first cycle of every rd_req, rd_valid
// follows in the next cycle, and wr_gnt is high in the first WRITE cycle:
//   each read = 2 cycles, each output element = DIM (COMPUTE) + 1 (WRITE)
//   per work item     = 2*DIM + DIM*(DIM+1) = DIM*DIM + 3*DIM  (28 for DIM=4)
//   matrix load       = 2*DIM*DIM                              (32 for DIM=4)
//   DONE              = 1
module matrix_vector_engine
    import matrix_vector_engine_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIM     = 4,
    parameter int WI_BITS = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               transpose,
    input  logic               reuseMatrix,
    input  logic [WI_BITS-1:0] workItemCount,
    input  logic [WIDTH-1:0]   matrixAddr,
    input  logic [WIDTH-1:0]   dataInAddr,
    input  logic [WIDTH-1:0]   dataOutAddr,
    output logic               rd_req,
    output logic [WIDTH-1:0]   rd_addr,
    input  logic               rd_gnt,
    input  logic               rd_valid,
    input  logic [WIDTH-1:0]   rd_data,
    output logic               wr_req,
    output logic [WIDTH-1:0]   wr_addr,
    output logic [WIDTH-1:0]   wr_data,
    input  logic               wr_gnt,
    output logic               busy,
    output logic               done
);

    localparam int BYTES = WIDTH / 8;
    localparam int MAT_N = DIM * DIM;
    localparam int MI_W  = $clog2(MAT_N);
    localparam int VW    = $clog2(DIM);

    state_t             state, state_nx;
    logic               trans_q;
    logic [WI_BITS-1:0] wi_total, item;
    logic [WIDTH-1:0]   mat_base, in_base, out_base;
    logic [MI_W-1:0]    fetch_cnt, load_last, mat_idx;
    logic [VW-1:0]      row, col;
    logic               outstanding;
    logic [WIDTH-1:0]   mat_cache [MAT_N];
    logic [WIDTH-1:0]   vec_cache [DIM];
    logic [WIDTH-1:0]   acc;
    logic [31:0]        vec_idx, out_idx;
    logic               loading, rd_done, load_fin, last_col, last_row, last_item;

    assign loading   = (state == LOAD_MAT) || (state == LOAD_VEC);
    // rd_valid only counts when this engine actually has a read in flight
    assign rd_done   = outstanding && rd_valid;
    assign load_last = (state == LOAD_MAT) ? MI_W'(MAT_N - 1) : MI_W'(DIM - 1);
    assign load_fin  = rd_done && (fetch_cnt == load_last);
    assign last_col  = (col == VW'(DIM - 1));
    assign last_row  = (row == VW'(DIM - 1));
    assign last_item = (item == wi_total - WI_BITS'(1));

    assign vec_idx = 32'(item) * 32'(DIM) + 32'(fetch_cnt);
    assign out_idx = 32'(item) * 32'(DIM) + 32'(row);
    assign mat_idx = trans_q ? MI_W'(32'(col) * 32'(DIM) + 32'(row))
                             : MI_W'(32'(row) * 32'(DIM) + 32'(col));

    // rd_addr/wr_addr/wr_data derive only from registers, so they stay
    // stable for as long as the request is held.
    assign rd_addr = (state == LOAD_MAT)
                   ? mat_base + WIDTH'(byte_offset(32'(fetch_cnt), BYTES))
                   : in_base  + WIDTH'(byte_offset(vec_idx, BYTES));
    assign wr_addr = out_base + WIDTH'(byte_offset(out_idx, BYTES));
    assign wr_data = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        rd_req   = loading && !outstanding;
        wr_req   = (state == WRITE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (workItemCount == '0)
                        state_nx = DONE;
                    else if (reuseMatrix)
                        state_nx = LOAD_VEC;
                    else
                        state_nx = LOAD_MAT;
                end
            end
            LOAD_MAT: if (load_fin) state_nx = LOAD_VEC;
            LOAD_VEC: if (load_fin) state_nx = COMPUTE;
            COMPUTE:  if (last_col) state_nx = WRITE;
            WRITE: begin
                if (wr_gnt) begin
                    if (!last_row)
                        state_nx = COMPUTE;
                    else if (last_item)
                        state_nx = DONE;
                    else
                        state_nx = LOAD_VEC;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_q     <= 1'b0;
            wi_total    <= '0;
            item        <= '0;
            mat_base    <= '0;
            in_base     <= '0;
            out_base    <= '0;
            fetch_cnt   <= '0;
            row         <= '0;
            col         <= '0;
            outstanding <= 1'b0;
            for (int n = 0; n < MAT_N; n++) mat_cache[n] <= '0;
            for (int n = 0; n < DIM; n++)   vec_cache[n] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        trans_q   <= transpose;
                        wi_total  <= workItemCount;
                        mat_base  <= matrixAddr;
                        in_base   <= dataInAddr;
                        out_base  <= dataOutAddr;
                        item      <= '0;
                        fetch_cnt <= '0;
                        row       <= '0;
                        col       <= '0;
                    end
                end
                LOAD_MAT, LOAD_VEC: begin
                    if (rd_req && rd_gnt)
                        outstanding <= 1'b1;
                    if (rd_done) begin
                        outstanding <= 1'b0;
                        if (state == LOAD_MAT)
                            mat_cache[fetch_cnt] <= rd_data;
                        else
                            vec_cache[fetch_cnt[VW-1:0]] <= rd_data;
                        fetch_cnt <= load_fin ? '0 : fetch_cnt + MI_W'(1);
                    end
                end
                COMPUTE: col <= last_col ? '0 : col + VW'(1);
                WRITE: begin
                    if (wr_gnt) begin
                        if (last_row) begin
                            row  <= '0;
                            item <= item + WI_BITS'(1);
                        end else begin
                            row <= row + VW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mac_unit #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (col == '0),
        .en    (state == COMPUTE),
        .a     (mat_cache[mat_idx]),
        .b     (vec_cache[col]),
        .acc   (acc)
    );

endmodule

// File: tb/tb_matrix_vector_engine.sv
// Bench for matrix_vector_engine (WIDTH=32, DIM=4): a memory responder serves
// reads, a write monitor pops the expected-write queue on every accepted write.
module tb_matrix_vector_engine;

    localparam int WIDTH = 32;
    localparam int DIM = 4;
    localparam int WI_BITS = 14;
    localparam logic [31:0] MBASE = 32'h1000;
    localparam logic [31:0] IBASE = 32'h2000;
    localparam logic [31:0] OBASE = 32'h3000;

    logic clk = 1'b0;
    logic rst, start, transpose, reuseMatrix;
    logic [WI_BITS-1:0] workItemCount;
    logic [WIDTH-1:0] matrixAddr, dataInAddr, dataOutAddr;
    logic rd_req, rd_gnt, rd_valid, wr_req, wr_gnt, busy, done;
    logic [WIDTH-1:0] rd_addr, rd_data, wr_addr, wr_data;

    always #5 clk = ~clk;

    matrix_vector_engine #(.WIDTH(WIDTH), .DIM(DIM), .WI_BITS(WI_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .transpose(transpose),
        .reuseMatrix(reuseMatrix), .workItemCount(workItemCount),
        .matrixAddr(matrixAddr), .dataInAddr(dataInAddr), .dataOutAddr(dataOutAddr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    bit          rand_mode = 1'b0;
    bit          wr_hold = 1'b0;
    int          mat_reads = 0;
    int          req_seen = 0;
    int          wr_count = 0;

    // read responder state
    bit          r_pend = 1'b0, r_held = 1'b0;
    int          r_gw = 0, r_vw = 0;
    logic [31:0] r_paddr = '0, r_haddr = '0;
    // write responder state
    bit          w_held = 1'b0;
    int          w_ww = 0;
    logic [31:0] w_haddr = '0, w_hdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick_delay();
        return rand_mode ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // Read responder: grants after gw cycles, returns data vw cycles after grant.
    initial begin
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            rd_gnt = 1'b0; rd_valid = 1'b0;
            if (rst) begin
                r_pend = 1'b0; r_held = 1'b0; r_gw = 0;
            end else begin
                if (rd_req || wr_req) req_seen++;
                if (r_pend) begin
                    check("rd_single_outstanding", rd_req, 0);
                    if (r_vw == 0) begin
                        rd_valid = 1'b1;
                        rd_data  = mem.exists(r_paddr) ? mem[r_paddr] : 32'h0;
                        r_pend   = 1'b0;
                    end else r_vw--;
                end else if (rd_req) begin
                    if (r_held) check("rd_addr_stable", rd_addr, r_haddr);
                    if (r_gw == 0) begin
                        rd_gnt  = 1'b1;
                        r_pend  = 1'b1;
                        r_paddr = rd_addr;
                        r_held  = 1'b0;
                        r_vw    = pick_delay();
                        r_gw    = pick_delay();
                        if (rd_addr >= MBASE && rd_addr < MBASE + 32'd64) mat_reads++;
                    end else begin
                        r_gw--;
                        r_held  = 1'b1;
                        r_haddr = rd_addr;
                    end
                end
            end
        end
    end

    // Write monitor: accepts writes and compares them against the scoreboard.
    initial begin
        wr_gnt = 1'b0;
        forever begin
            @(negedge clk);
            wr_gnt = 1'b0;
            if (rst) begin
                w_held = 1'b0; w_ww = 0;
            end else if (wr_req) begin
                if (w_held) begin
                    check("wr_addr_stable", wr_addr, w_haddr);
                    check("wr_data_stable", wr_data, w_hdata);
                end
                if (!wr_hold && w_ww == 0) begin
                    wr_gnt = 1'b1;
                    wr_count++;
                    w_held = 1'b0;
                    w_ww   = pick_delay();
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", wr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                end else begin
                    if (w_ww > 0) w_ww--;
                    w_held  = 1'b1;
                    w_haddr = wr_addr;
                    w_hdata = wr_data;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int idx, input logic [31:0] data);
        wr_t x;
        x.addr = OBASE + 32'(idx * 4);
        x.data = data;
        exp_q.push_back(x);
    endtask

    task automatic set_vec(input int item, input logic [31:0] v0, v1, v2, v3);
        mem[IBASE + 32'(item * 16)]      = v0;
        mem[IBASE + 32'(item * 16 + 4)]  = v1;
        mem[IBASE + 32'(item * 16 + 8)]  = v2;
        mem[IBASE + 32'(item * 16 + 12)] = v3;
    endtask

    // kind 0: identity, 1: r*4+c, 2: all ones-bits
    task automatic set_mat(input int kind);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[MBASE + 32'((r * 4 + c) * 4)] =
                    (kind == 0) ? ((r == c) ? 32'd1 : 32'd0) :
                    (kind == 1) ? 32'(r * 4 + c) : 32'hFFFF_FFFF;
    endtask

    task automatic launch(input bit tr, input bit reuse, input int cnt);
        @(negedge clk);
        transpose = tr; reuseMatrix = reuse; workItemCount = WI_BITS'(cnt);
        matrixAddr = MBASE; dataInAddr = IBASE; dataOutAddr = OBASE;
        mat_reads = 0; req_seen = 0; wr_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // scrambled job inputs must not disturb the running job
        transpose = ~tr; reuseMatrix = ~reuse; workItemCount = WI_BITS'(3);
        matrixAddr = 32'hDEAD_0000; dataInAddr = 32'hBEEF_0000; dataOutAddr = 32'hCAFE_0000;
    endtask

    task automatic run_job(input bit tr, input bit reuse, input int cnt,
                           output int cyc, output int dn);
        launch(tr, reuse, cnt);
        cyc = 0; dn = 0;
        while (busy && cyc < 5000) begin
            start = (cyc == 3);
            if (done) dn++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (busy) check("job_timeout", 1, 0);
    endtask

    int cyc, dn, waited;

    initial begin
        rst = 1'b1; start = 1'b0; transpose = 1'b0; reuseMatrix = 1'b0;
        workItemCount = '0; matrixAddr = '0; dataInAddr = '0; dataOutAddr = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_req", rd_req, 0);
        check("reset_wr_req", wr_req, 0);
        rst = 1'b0;

        // reuse before any matrix load: zero matrix
        set_vec(0, 1, 2, 3, 4);
        for (int i = 0; i < 4; i++) push_exp(i, 0);
        run_job(0, 1, 1, cyc, dn);
        check("t0_cycles", cyc, 29);
        check("t0_done", dn, 1);
        check("t0_mat_reads", mat_reads, 0);
        check("t0_drain", exp_q.size(), 0);

        // identity, two items
        set_mat(0);
        set_vec(0, 1, 2, 3, 4);
        set_vec(1, 5, 6, 7, 8);
        for (int i = 0; i < 8; i++) push_exp(i, 32'(i + 1));
        run_job(0, 0, 2, cyc, dn);
        check("t1_cycles", cyc, 89);
        check("t1_done", dn, 1);
        check("t1_mat_reads", mat_reads, 16);
        check("t1_drain", exp_q.size(), 0);

        // M[r][c] = r*4+c, v = ones
        set_mat(1);
        set_vec(0, 1, 1, 1, 1);
        push_exp(0, 6); push_exp(1, 22); push_exp(2, 38); push_exp(3, 54);
        run_job(0, 0, 1, cyc, dn);
        check("t2_cycles", cyc, 61);
        check("t2_done", dn, 1);
        check("t2_drain", exp_q.size(), 0);

        // transpose with cached matrix
        push_exp(0, 24); push_exp(1, 28); push_exp(2, 32); push_exp(3, 36);
        run_job(1, 1, 1, cyc, dn);
        check("t3_cycles", cyc, 29);
        check("t3_mat_reads", mat_reads, 0);
        check("t3_done", dn, 1);
        check("t3_drain", exp_q.size(), 0);

        // identity with random handshake delays
        rand_mode = 1'b1;
        set_mat(0);
        set_vec(0, 1, 2, 3, 4);
        set_vec(1, 5, 6, 7, 8);
        for (int i = 0; i < 8; i++) push_exp(i, 32'(i + 1));
        run_job(0, 0, 2, cyc, dn);
        check("t4_done", dn, 1);
        check("t4_drain", exp_q.size(), 0);

        // zero work items
        rand_mode = 1'b0;
        run_job(0, 0, 0, cyc, dn);
        check("t5_cycles", cyc, 1);
        check("t5_done", dn, 1);
        check("t5_no_traffic", req_seen, 0);

        // reset while a write is pending
        wr_hold = 1'b1;
        push_exp(0, 1);
        launch(0, 1, 1);
        waited = 0;
        while (!wr_req && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("t6_wr_pending", wr_req, 1);
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_wr_req", wr_req, 0);
        check("t6_rd_req", rd_req, 0);
        check("t6_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        wr_hold = 1'b0;

        // caches cleared by reset
        for (int i = 0; i < 4; i++) push_exp(i, 0);
        run_job(0, 1, 1, cyc, dn);
        check("t7_done", dn, 1);
        check("t7_drain", exp_q.size(), 0);

        // modulo wrap with random delays
        rand_mode = 1'b1;
        set_mat(2);
        set_vec(0, 2, 2, 2, 2);
        for (int i = 0; i < 4; i++) push_exp(i, 32'hFFFF_FFF8);
        run_job(0, 0, 1, cyc, dn);
        check("t8_done", dn, 1);
        check("t8_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
